// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the cv32e40x interrupt arbiter slice.
// Holds the privilege-level type, the arbiter FSM encoding and the priority IDs.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } PrivLvl_t;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_PENDING = 2'd1,
        IRQ_ACKED   = 2'd2
    } irq_arb_state_e;

    localparam logic [31:0] IRQ_MASK_DEFAULT = 32'hFFFF_0888;

    localparam logic [4:0] IRQ_ID_MEI = 5'd11;
    localparam logic [4:0] IRQ_ID_MSI = 5'd3;
    localparam logic [4:0] IRQ_ID_MTI = 5'd7;

endpackage

// File: rtl/cv32e40x_irq_sync.sv
// 32-bit two-flop synchronizer for asynchronous interrupt sources.
// Built only when CV32E40X_IRQ_SYNC_EN is defined; it is unused otherwise.
`ifdef CV32E40X_IRQ_SYNC_EN
module cv32e40x_irq_sync (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] irq_i,
    output logic [31:0] irq_sync_o
);

    logic [31:0] meta_d, meta_q;
    logic [31:0] sync_d, sync_q;

    always_comb begin
        meta_d = irq_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign irq_sync_o = sync_q;

endmodule
`endif

// File: rtl/cv32e40x_irq_arbiter.sv
// Interrupt arbiter feeding the controller: pending image, mask/enable, priority select and ack handshake.
// Define CV32E40X_IRQ_SYNC_EN to pass irq_i through a 2-flop synchronizer first.
module cv32e40x_irq_arbiter
    import cv32e40x_pkg::*;
#(
    parameter logic [31:0] IRQ_MASK = IRQ_MASK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] irq_i,
    input  logic [31:0] mie_i,
    input  logic        m_ie_i,
    input  PrivLvl_t    current_priv_lvl_i,
    input  logic        irq_ack_i,
    output logic [31:0] mip_o,
    output logic        irq_req_ctrl_o,
    output logic [4:0]  irq_id_ctrl_o,
    output logic        irq_wu_ctrl_o
);

    logic [31:0]    irq_in;
    logic [31:0]    mip_d, mip_q;
    logic [31:0]    pend;
    logic           gen;
    logic [4:0]     sel_id;
    logic           sel_vld;
    irq_arb_state_e state_d, state_q;
    logic           req_d, req_q;
    logic [4:0]     id_d, id_q;

`ifdef CV32E40X_IRQ_SYNC_EN
    cv32e40x_irq_sync u_irq_sync (
        .clk        (clk),
        .rst        (rst),
        .irq_i      (irq_i),
        .irq_sync_o (irq_in)
    );
`else
    assign irq_in = irq_i;
`endif

    assign mip_d = irq_in & IRQ_MASK;
    assign pend  = mip_q & mie_i;
    // Below M-mode, M-level interrupts are always globally enabled.
    assign gen   = (current_priv_lvl_i == PRIV_LVL_M) ? m_ie_i : 1'b1;

    // Lowest priority is written first so each later hit overrides it:
    // 7, then 3, then 11, then platform lines 16..31 ascending.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel_vld = 1'b0;
        sel_id  = '0;
        if (pend[IRQ_ID_MTI]) begin
            sel_vld = 1'b1;
            sel_id  = IRQ_ID_MTI;
        end
        if (pend[IRQ_ID_MSI]) begin
            sel_vld = 1'b1;
            sel_id  = IRQ_ID_MSI;
        end
        if (pend[IRQ_ID_MEI]) begin
            sel_vld = 1'b1;
            sel_id  = IRQ_ID_MEI;
        end
        for (int i = 16; i < 32; i++) begin
            if (pend[i]) begin
                sel_vld = 1'b1;
                sel_id  = 5'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        unique case (state_q)
            IRQ_IDLE: begin
                if (sel_vld && gen) begin
                    state_d = IRQ_PENDING;
                    req_d   = 1'b1;
                    id_d    = sel_id;
                end
            end
            IRQ_PENDING: begin
                if (irq_ack_i) begin
                    state_d = IRQ_ACKED;
                    req_d   = 1'b0;
                end else if (pend[id_q] && gen) begin
                    // ID stays frozen until acked, even if a higher-priority line arrives.
                    state_d = IRQ_PENDING;
                end else if (sel_vld && gen) begin
                    id_d = sel_id;
                end else begin
                    state_d = IRQ_IDLE;
                    req_d   = 1'b0;
                end
            end
            IRQ_ACKED: begin
                // One-cycle blackout gives the controller time to clear mstatus.MIE.
                state_d = IRQ_IDLE;
                req_d   = 1'b0;
            end
            default: begin
                state_d = IRQ_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mip_q   <= '0;
            state_q <= IRQ_IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            mip_q   <= mip_d;
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
        end
    end

    assign mip_o          = mip_q;
    assign irq_req_ctrl_o = req_q;
    assign irq_id_ctrl_o  = id_q;
    assign irq_wu_ctrl_o  = |pend;

    a_ack_only_when_pending : assert property (
        @(posedge clk) disable iff (rst) irq_ack_i |-> (state_q == IRQ_PENDING)
    ) else $error("irq_ack_i asserted outside the PENDING state");

endmodule

// File: tb/tb_cv32e40x_irq_arbiter.sv
// Directed self-checking bench for cv32e40x_irq_arbiter; adapts its latency
// expectations when CV32E40X_IRQ_SYNC_EN is defined.
module tb_cv32e40x_irq_arbiter;
    import cv32e40x_pkg::*;

`ifdef CV32E40X_IRQ_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] irq_i;
    logic [31:0] mie_i;
    logic        m_ie_i;
    PrivLvl_t    priv;
    logic        irq_ack_i;
    logic [31:0] mip_o;
    logic        irq_req_ctrl_o;
    logic [4:0]  irq_id_ctrl_o;
    logic        irq_wu_ctrl_o;

    int n_vec;
    int n_err;

    cv32e40x_irq_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .irq_i              (irq_i),
        .mie_i              (mie_i),
        .m_ie_i             (m_ie_i),
        .current_priv_lvl_i (priv),
        .irq_ack_i          (irq_ack_i),
        .mip_o              (mip_o),
        .irq_req_ctrl_o     (irq_req_ctrl_o),
        .irq_id_ctrl_o      (irq_id_ctrl_o),
        .irq_wu_ctrl_o      (irq_wu_ctrl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; irq_i = '0; mie_i = '0; m_ie_i = 1'b0;
        priv = PRIV_LVL_M; irq_ack_i = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        n_vec++; if (mip_o !== 32'h0) begin n_err++; $display("FAIL reset_mip: got %h want %h", mip_o, 32'h0); end
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", irq_req_ctrl_o); end
        n_vec++; if (irq_id_ctrl_o !== 5'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", irq_id_ctrl_o); end
        n_vec++; if (irq_wu_ctrl_o !== 1'b0) begin n_err++; $display("FAIL reset_wu: got %b want 0", irq_wu_ctrl_o); end
    endtask

    task automatic test_priority_freeze;
        mie_i = '1; m_ie_i = 1'b1; priv = PRIV_LVL_M;
        irq_i = 32'h0000_0080;
        tick(1 + L);
        n_vec++; if (mip_o !== 32'h0000_0080) begin n_err++; $display("FAIL pf_mip_latency: got %h want %h", mip_o, 32'h80); end
        n_vec++; if (irq_wu_ctrl_o !== 1'b1) begin n_err++; $display("FAIL pf_wu_latency: got %b want 1", irq_wu_ctrl_o); end
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL pf_req_early: got %b want 0", irq_req_ctrl_o); end
        tick(1);
        n_vec++; if (irq_req_ctrl_o !== 1'b1) begin n_err++; $display("FAIL pf_req_latency: got %b want 1", irq_req_ctrl_o); end
        n_vec++; if (irq_id_ctrl_o !== 5'd7) begin n_err++; $display("FAIL pf_id7: got %0d want 7", irq_id_ctrl_o); end
        irq_i = 32'h0000_0880;
        tick(2 + L);
        n_vec++; if (irq_id_ctrl_o !== 5'd7) begin n_err++; $display("FAIL pf_freeze_id: got %0d want 7", irq_id_ctrl_o); end
        n_vec++; if (mip_o !== 32'h0000_0880) begin n_err++; $display("FAIL pf_freeze_mip: got %h want %h", mip_o, 32'h880); end
        irq_i = 32'h0000_0800;
        tick(2 + L);
        n_vec++; if (irq_id_ctrl_o !== 5'd11) begin n_err++; $display("FAIL pf_reselect_id: got %0d want 11", irq_id_ctrl_o); end
        n_vec++; if (irq_req_ctrl_o !== 1'b1) begin n_err++; $display("FAIL pf_reselect_req: got %b want 1", irq_req_ctrl_o); end
    endtask

    task automatic test_platform_lines;
        irq_i = '0;
        tick(2 + L);
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL plat_idle_req: got %b want 0", irq_req_ctrl_o); end
        irq_i = 32'h0001_0808;
        tick(2 + L);
        n_vec++; if (irq_id_ctrl_o !== 5'd16) begin n_err++; $display("FAIL plat_id16: got %0d want 16", irq_id_ctrl_o); end
        n_vec++; if (irq_req_ctrl_o !== 1'b1) begin n_err++; $display("FAIL plat_req: got %b want 1", irq_req_ctrl_o); end
        irq_i = 32'h0000_0808;
        tick(2 + L);
        n_vec++; if (irq_id_ctrl_o !== 5'd11) begin n_err++; $display("FAIL plat_id11: got %0d want 11", irq_id_ctrl_o); end
        n_vec++; if (irq_req_ctrl_o !== 1'b1) begin n_err++; $display("FAIL plat_req_after_drop: got %b want 1", irq_req_ctrl_o); end
    endtask

    task automatic test_global_enable;
        irq_i = '0;
        tick(2 + L);
        m_ie_i = 1'b0;
        irq_i = 32'h0000_0800;
        tick(3 + L);
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL gen_req_off: got %b want 0", irq_req_ctrl_o); end
        n_vec++; if (irq_wu_ctrl_o !== 1'b1) begin n_err++; $display("FAIL gen_wu: got %b want 1", irq_wu_ctrl_o); end
        n_vec++; if (mip_o !== 32'h0000_0800) begin n_err++; $display("FAIL gen_mip: got %h want %h", mip_o, 32'h800); end
        priv = PRIV_LVL_U;
        tick(2);
        n_vec++; if (irq_req_ctrl_o !== 1'b1) begin n_err++; $display("FAIL gen_umode_req: got %b want 1", irq_req_ctrl_o); end
        n_vec++; if (irq_id_ctrl_o !== 5'd11) begin n_err++; $display("FAIL gen_umode_id: got %0d want 11", irq_id_ctrl_o); end
        priv = PRIV_LVL_M;
        m_ie_i = 1'b1;
    endtask

    task automatic test_ack_handshake;
        tick(1);
        n_vec++; if (irq_req_ctrl_o !== 1'b1) begin n_err++; $display("FAIL ack_pre_req: got %b want 1", irq_req_ctrl_o); end
        irq_ack_i = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL ack_m_req: got %b want 0", irq_req_ctrl_o); end
        n_vec++; if (irq_id_ctrl_o !== 5'd11) begin n_err++; $display("FAIL ack_m_id: got %0d want 11", irq_id_ctrl_o); end
        tick(1);
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL ack_blackout_req: got %b want 0", irq_req_ctrl_o); end
        tick(1);
        n_vec++; if (irq_req_ctrl_o !== 1'b1) begin n_err++; $display("FAIL ack_rearm_req: got %b want 1", irq_req_ctrl_o); end
        n_vec++; if (irq_id_ctrl_o !== 5'd11) begin n_err++; $display("FAIL ack_rearm_id: got %0d want 11", irq_id_ctrl_o); end
        // Ack coincides with loss of pend[11]; ack must win, leaving a blackout before MSI.
        irq_i = 32'h0000_0808;
        tick(2 + L);
        n_vec++; if (irq_id_ctrl_o !== 5'd11) begin n_err++; $display("FAIL ackdrop_pre_id: got %0d want 11", irq_id_ctrl_o); end
        irq_ack_i = 1'b1;
        mie_i = ~32'h0000_0800;
        tick(1);
        irq_ack_i = 1'b0;
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL ackdrop_m_req: got %b want 0", irq_req_ctrl_o); end
        tick(1);
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL ackdrop_blackout_req: got %b want 0", irq_req_ctrl_o); end
        tick(1);
        n_vec++; if (irq_req_ctrl_o !== 1'b1) begin n_err++; $display("FAIL ackdrop_rearm_req: got %b want 1", irq_req_ctrl_o); end
        n_vec++; if (irq_id_ctrl_o !== 5'd3) begin n_err++; $display("FAIL ackdrop_rearm_id: got %0d want 3", irq_id_ctrl_o); end
        mie_i = '1;
    endtask

    task automatic test_masking;
        irq_i = '0;
        tick(2 + L);
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL mask_idle_req: got %b want 0", irq_req_ctrl_o); end
        irq_i = 32'h0000_F777;
        tick(3 + L);
        n_vec++; if (mip_o !== 32'h0) begin n_err++; $display("FAIL mask_mip: got %h want %h", mip_o, 32'h0); end
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL mask_req: got %b want 0", irq_req_ctrl_o); end
        n_vec++; if (irq_wu_ctrl_o !== 1'b0) begin n_err++; $display("FAIL mask_wu: got %b want 0", irq_wu_ctrl_o); end
    endtask

    task automatic test_reset_mid;
        irq_i = 32'h0000_0080;
        tick(2 + L);
        n_vec++; if (irq_req_ctrl_o !== 1'b1) begin n_err++; $display("FAIL rmid_pre_req: got %b want 1", irq_req_ctrl_o); end
        n_vec++; if (irq_id_ctrl_o !== 5'd7) begin n_err++; $display("FAIL rmid_pre_id: got %0d want 7", irq_id_ctrl_o); end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (mip_o !== 32'h0) begin n_err++; $display("FAIL rmid_mip: got %h want %h", mip_o, 32'h0); end
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL rmid_req: got %b want 0", irq_req_ctrl_o); end
        n_vec++; if (irq_id_ctrl_o !== 5'd0) begin n_err++; $display("FAIL rmid_id: got %0d want 0", irq_id_ctrl_o); end
        n_vec++; if (irq_wu_ctrl_o !== 1'b0) begin n_err++; $display("FAIL rmid_wu: got %b want 0", irq_wu_ctrl_o); end
        tick(2);
        rst = 1'b0;
        tick(1 + L);
        n_vec++; if (irq_req_ctrl_o !== 1'b0) begin n_err++; $display("FAIL rmid_post_req_early: got %b want 0", irq_req_ctrl_o); end
        n_vec++; if (mip_o !== 32'h0000_0080) begin n_err++; $display("FAIL rmid_post_mip: got %h want %h", mip_o, 32'h80); end
        tick(1);
        n_vec++; if (irq_req_ctrl_o !== 1'b1) begin n_err++; $display("FAIL rmid_post_req: got %b want 1", irq_req_ctrl_o); end
        n_vec++; if (irq_id_ctrl_o !== 5'd7) begin n_err++; $display("FAIL rmid_post_id: got %0d want 7", irq_id_ctrl_o); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_priority_freeze();
        test_platform_lines();
        test_global_enable();
        test_ack_handshake();
        test_masking();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40x_irq_arbiter.md
# cv32e40x_irq_arbiter

Interrupt arbiter directly upstream of the core controller. It samples the external interrupt lines, maintains the machine interrupt-pending image, and applies the `mie` mask and `mstatus.MIE` global enable. It then produces the registered request, the interrupt ID and the wake-up signal consumed by the controller FSM (`irq_req_ctrl`, `irq_id_ctrl`, `irq_wu_ctrl`). A small handshake FSM keeps the presented ID stable until the controller acknowledges it.

## Interface
Parameters:
- `IRQ_MASK`, default `32'hFFFF_0888`: implemented interrupt lines (31:16, 11, 7, 3). Other lines read as 0.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `irq_i`  in  32  level-sensitive interrupt lines.
- `mie_i`  in  32  CSR `mie`.
- `m_ie_i`  in  1  CSR `mstatus.MIE`.
- `current_priv_lvl_i`  in  PrivLvl_t  current privilege level.
- `irq_ack_i`  in  1  one-cycle pulse from the controller FSM when it takes the presented interrupt.
- `mip_o`  out  32  registered pending image, for CSR reads.
- `irq_req_ctrl_o`  out  1  registered interrupt request to the controller.
- `irq_id_ctrl_o`  out  5  registered ID of the requested interrupt.
- `irq_wu_ctrl_o`  out  1  wake-up: any enabled pending line, ignoring global enable.

## Operation
- Pending image: `mip_q <= irq_in & IRQ_MASK` every cycle. `irq_in` is `irq_i`, or its synchronized copy (see Configuration). `mip_o = mip_q`.
- Enabled set: `pend = mip_q & mie_i`.
- Global enable: `gen = m_ie_i` when priv is M; `gen = 1` when priv is below M.
- Priority order, highest first: 31, 30 … 16, then 11, 3, 7. Selection is a combinational find-first over `pend`, giving `sel_id` and `sel_vld`.
- `irq_wu_ctrl_o = |pend`. It is combinational from registered `mip_q`, and is valid even when `gen = 0`.
- FSM states: IDLE, PENDING, ACKED.
  - IDLE: if `sel_vld & gen`, then go to PENDING, with `req_q <= 1` and `id_q <= sel_id`.
  - PENDING, with `irq_ack_i`: go to ACKED, `req_q <= 0`, `id_q` held.
  - PENDING, `pend[id_q] & gen`, no ack: stay in PENDING. `id_q` is frozen even if a higher-priority line arrives.
  - PENDING, `pend[id_q]` dropped or `gen = 0`, no ack: if `sel_vld & gen`, reselect, with `id_q <= sel_id` and `req_q` stays 1. Otherwise go to IDLE with `req_q <= 0`.
  - ACKED: go to IDLE unconditionally after one cycle, with `req_q = 0`. This blackout lets the controller clear `mstatus.MIE`.
- `irq_ack_i` in IDLE or ACKED is ignored. An assertion flags it.
- `irq_req_ctrl_o = req_q` and `irq_id_ctrl_o = id_q`.

## Timing
- Reset values: `mip_q = 0`, `req_q = 0`, `id_q = 0`, state IDLE, all sync flops 0. Consequently `mip_o = 0`, `irq_wu_ctrl_o = 0`, `irq_req_ctrl_o = 0`, `irq_id_ctrl_o = 0`.
- Latency without sync, when `irq_i[k]` rises before edge N with `mie` and `gen` set:
  - `mip_o[k]` and `irq_wu_ctrl_o` are high after edge N.
  - `irq_req_ctrl_o` is high after edge N+1.
- Sync compiled in: add 2 cycles to both latencies.
- Ack at edge M: `req` is low after M, stays low after M+1 (ACKED), and can re-assert after M+2 at the earliest.
- Simultaneous ack and drop of `pend[id_q]`: the ack wins and the FSM goes to ACKED.
- `rst` asserted mid-handshake: all outputs clear immediately (asynchronous). After deassertion the FSM starts in IDLE.

## Configuration
- `CV32E40X_IRQ_SYNC_EN` defined: `irq_i` passes through a 2-flop synchronizer (reset to 0) before `mip_q`, for asynchronous interrupt sources.
- `CV32E40X_IRQ_SYNC_EN` undefined: `irq_i` feeds `mip_q` directly. The sources must be synchronous to `clk`.

## Structure
- In `cv32e40x_pkg`:
  - the `irq_arb_state_e` enum {IRQ_IDLE, IRQ_PENDING, IRQ_ACKED};
  - the constant `IRQ_MASK_DEFAULT = 32'hFFFF_0888`;
  - the priority ID constants `IRQ_ID_MEI = 5'd11`, `IRQ_ID_MSI = 5'd3`, `IRQ_ID_MTI = 5'd7`.
- Sub-module `cv32e40x_irq_sync`: a 32-bit 2-flop synchronizer with asynchronous active-high reset. It is instantiated only under the macro.

## Test plan
1. Priority and freeze.
   - Stimulus: `irq_i = 32'h0000_0080`, `mie = '1`, `m_ie = 1`, M-mode.
   - Response: `req` after 2 cycles with `id = 7`.
   - Then raise bit 11 without an ack: `id` stays 7.
   - Then drop bit 7: `id` becomes 11 and `req` stays 1.
2. Platform versus standard lines.
   - Stimulus: `irq_i = 32'h0001_0808`.
   - Response: `id = 16`.
   - Then clear bit 16: `id = 11`.
3. Global enable.
   - Stimulus: `m_ie = 0`, `irq_i = 32'h0000_0800`.
   - Response: `req = 0`, `irq_wu_ctrl_o = 1`, `mip_o = 32'h0000_0800`.
   - Switch priv to U: `req = 1` two cycles later (with the same ID). Note: PrivLvl_t must have U; if only M exists, skip this part.
4. Ack handshake.
   - Stimulus: `req` high with `id = 11`; pulse `irq_ack_i`.
   - Response: `req` low for 2 cycles, then re-asserts with `id = 11` if the line is still high.
5. Masking.
   - Stimulus: `irq_i = 32'h0000_F777` (unimplemented lines only).
   - Response: `mip_o = 0`, `req = 0`, `wu = 0`.
6. Reset and sync.
   - Assert `rst` while in PENDING: all outputs are 0 within the same cycle.
   - With `CV32E40X_IRQ_SYNC_EN` defined, repeat scenario 1: `req` arrives 4 cycles after `irq_i`.
